axi_trace_ctrl: RTL and testbench
=================================

Name: axi_trace_ctrl

Overview:
- Trigger/window controller that decides which handshaked AXI beats get logged.
- Watches the same axi_req_t/axi_resp_t pair as the simulation dumper.
- Arms on software command, fires on an address-matched AW/AR handshake, then qualifies a bounded number of beats.
- Emits per-channel log-valid strobes and status. Synthesizable, so it can also gate an on-chip trace sink.

Parameters:
- axi_req_t, logic, AXI request struct type (aw/w/ar channels, valids, b_ready/r_ready).
- axi_resp_t, logic, AXI response struct type (b/r channels, readies, b_valid/r_valid).
- AddrWidth, 64, width of the trigger base/mask compare.
- CntWidth, 16, width of the beat counter and capture length.
- TimeoutCycles, 1024, idle-cycle limit for the optional timeout feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- axi_req_i  in  axi_req_t  monitored request (observe only)
- axi_resp_i  in  axi_resp_t  monitored response (observe only)
- arm_i  in  1  pulse: arm trigger
- disarm_i  in  1  pulse: abort, return to IDLE
- trig_on_aw_i  in  1  AW handshakes may trigger
- trig_on_ar_i  in  1  AR handshakes may trigger
- trig_base_i  in  AddrWidth  trigger address base
- trig_mask_i  in  AddrWidth  compare mask (1 = bit compared)
- chan_en_i  in  5  channel enables, bit order {R,B,W,AR,AW}
- capture_len_i  in  CntWidth  beats to capture; 0 = unlimited
- log_valid_o  in/out: out  5  per-channel "log this beat" strobe, bit order {R,B,W,AR,AW}
- state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- beat_cnt_o  out  CntWidth  beats qualified in the current window
- triggered_o  out  1  sticky: trigger fired since last arm
- timeout_o  out  1  sticky: window closed by timeout (0 when feature off)

Behaviour:
- Handshake per channel:
  - AW: aw_valid & aw_ready; AR: ar_valid & ar_ready; W: w_valid & w_ready.
  - B: b_valid & b_ready; R: r_valid & r_ready.
  - Qualified handshake: hs[i] & chan_en_i[i].
- Reset (rst_ni low at posedge): state IDLE, beat_cnt 0, triggered 0, timeout 0, log_valid_o 0.
- Trigger match, same cycle:
  - (trig_on_aw_i & AW hs & ((aw.addr ^ trig_base_i) & trig_mask_i) == 0), OR
  - the same expression on the AR channel.
  - The address is zero-extended or truncated to AddrWidth.
- IDLE: arm_i -> ARMED; beat_cnt and sticky flags clear on that edge.
- ARMED: on match -> CAPTURE; triggered_o set.
  - The trigger cycle itself is inside the window: all qualified handshakes that cycle assert log_valid_o and are counted.
- CAPTURE:
  - log_valid_o = qualified handshakes, combinational from the inputs, zero-latency.
  - beat_cnt += popcount(log_valid_o), 0..5 per cycle, saturating at all-ones.
- Window close with capture_len_i != 0:
  - Once beat_cnt + popcount >= capture_len_i, the next state is DONE.
  - Beats in the crossing cycle are all logged; overshoot of up to 4 beats is allowed and visible in beat_cnt_o.
- DONE: log_valid_o = 0; beat_cnt holds; arm_i -> ARMED (counter and flags clear).
- disarm_i: any state -> IDLE next edge. beat_cnt and flags hold until the next arm.
  - Simultaneous arm_i & disarm_i: disarm wins.
  - arm_i in ARMED or CAPTURE: ignored.
- log_valid_o is 0 in IDLE, ARMED (except the trigger cycle) and DONE.
- Changing capture_len_i or the trigger config mid-window takes effect immediately. Legal, but software should not do it.
- Reset mid-CAPTURE: immediate return to reset values; no partial state retained.

Optional Feature:
- Macro: AXI_TRACE_CTRL_TIMEOUT_EN.
- Defined:
  - Idle counter (clog2(TimeoutCycles+1) bits) runs in CAPTURE. It clears on any cycle with a qualified handshake and clears on entering CAPTURE.
  - On reaching TimeoutCycles -> DONE, timeout_o set (sticky until next arm).
  - Timeout and len-complete in the same cycle: DONE with timeout_o = 0.
- Undefined: no counter; timeout_o tied 0; CAPTURE exits only on length or disarm.

Test Plan:
- Mask 0xFFFF_F000, base 0x8000_0000, trig_on_ar=1, len=3, chan_en=AR|R. Arm; AR to 0x8000_0010 then 3 R beats -> AR and first 2 R beats logged, state DONE after the crossing cycle, beat_cnt=3.
- ARMED; AW to 0x8000_0000 with trig_on_aw=0, then AR to 0x4000_0000 -> no trigger, log_valid_o stays 0, state ARMED.
- len=2, all channels enabled; AW, W and B handshake in the trigger cycle -> 3 beats logged that cycle, beat_cnt=3, DONE next.
- CAPTURE with len=0; 70000 R beats -> beat_cnt saturates at 0xFFFF, state stays CAPTURE; disarm_i -> IDLE.
- arm_i and disarm_i in the same cycle from DONE -> IDLE. rst_ni low mid-CAPTURE -> all outputs at reset values next edge.
- With AXI_TRACE_CTRL_TIMEOUT_EN and TimeoutCycles=8: trigger, then 8 idle cycles -> DONE, timeout_o=1. Re-arm -> timeout_o=0.

Source files
------------

// File: rtl/axi_trace_ctrl.sv
// axi_trace_ctrl: trigger/window controller that selects which handshaked AXI
// beats get logged. Software arms it. The first address-matched AW/AR
// handshake opens a capture window, and the window then qualifies a bounded
// number of beats.
//
// Build option: define AXI_TRACE_CTRL_TIMEOUT_EN to close a capture window
// after TimeoutCycles consecutive cycles without a qualified handshake.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   axi_req_i/resp_i     monitored AXI request/response (observe only)
//   arm_i, disarm_i      software arm / abort pulses
//   trig_on_aw/ar_i      channels allowed to trigger
//   trig_base/mask_i     address compare (mask bit 1 = compared)
//   chan_en_i            channel enables {R,B,W,AR,AW}
//   capture_len_i        beats per window, 0 = unlimited
//   log_valid_o          per-channel log strobe {R,B,W,AR,AW}, combinational
//   state_o              0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   beat_cnt_o           beats qualified in the current window (saturating)
//   triggered_o          sticky, set when the trigger fires
//   timeout_o            sticky, set when the window is closed by idle timeout

package axi_trace_pkg;
    localparam int unsigned AxiAddrWidth = 64;
    localparam int unsigned AxiDataWidth = 64;

    typedef struct packed {
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
    } axi_ax_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0] data;
        logic                    last;
    } axi_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        logic   ar_ready;
        axi_r_t r;
        logic   r_valid;
    } axi_resp_t;
endpackage

module axi_trace_ctrl #(
    parameter type         axi_req_t     = axi_trace_pkg::axi_req_t,
    parameter type         axi_resp_t    = axi_trace_pkg::axi_resp_t,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  axi_req_t             axi_req_i,
    input  axi_resp_t            axi_resp_i,
    input  logic                 arm_i,
    input  logic                 disarm_i,
    input  logic                 trig_on_aw_i,
    input  logic                 trig_on_ar_i,
    input  logic [AddrWidth-1:0] trig_base_i,
    input  logic [AddrWidth-1:0] trig_mask_i,
    input  logic [4:0]           chan_en_i,
    input  logic [CntWidth-1:0]  capture_len_i,
    output logic [4:0]           log_valid_o,
    output logic [1:0]           state_o,
    output logic [CntWidth-1:0]  beat_cnt_o,
    output logic                 triggered_o,
    output logic                 timeout_o
);

    localparam int unsigned SumWidth = CntWidth + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e              r_state, w_state_nxt;
    logic [CntWidth-1:0] r_beat_cnt, w_cnt_nxt;
    logic                r_triggered, w_trig_nxt;
    logic                r_timeout, w_to_nxt;

    logic [4:0]          w_hs, w_qual;
    logic                w_aw_match, w_ar_match, w_trig, w_arm, w_in_window;
    logic [2:0]          w_pop;
    logic [SumWidth-1:0] w_sum;
    logic [CntWidth-1:0] w_cnt_sat;
    logic                w_len_done;
    logic                w_unused;

    // Handshakes, bit order {R,B,W,AR,AW}
    assign w_hs = {axi_resp_i.r_valid  & axi_req_i.r_ready,
                   axi_resp_i.b_valid  & axi_req_i.b_ready,
                   axi_req_i.w_valid   & axi_resp_i.w_ready,
                   axi_req_i.ar_valid  & axi_resp_i.ar_ready,
                   axi_req_i.aw_valid  & axi_resp_i.aw_ready};
    assign w_qual = w_hs & chan_en_i;

    // Trigger uses the raw handshake; channel enables only gate logging
    assign w_aw_match = trig_on_aw_i & w_hs[0] &
        (((AddrWidth'(axi_req_i.aw.addr) ^ trig_base_i) & trig_mask_i) == '0);
    assign w_ar_match = trig_on_ar_i & w_hs[1] &
        (((AddrWidth'(axi_req_i.ar.addr) ^ trig_base_i) & trig_mask_i) == '0);
    assign w_trig = w_aw_match | w_ar_match;

    // Disarm has priority over a simultaneous arm
    assign w_arm = arm_i & ~disarm_i;

    // The trigger cycle is part of the window
    assign w_in_window = (r_state == ST_CAPTURE) | ((r_state == ST_ARMED) & w_trig);

    always_comb begin
        log_valid_o = '0;
        if (w_in_window) log_valid_o = w_qual;
    end

    // Unsaturated sum drives the length compare; the stored count saturates
    assign w_pop      = 3'($countones(log_valid_o));
    assign w_sum      = {1'b0, r_beat_cnt} + SumWidth'(w_pop);
    assign w_cnt_sat  = w_sum[CntWidth] ? '1 : w_sum[CntWidth-1:0];
    assign w_len_done = (capture_len_i != '0) && (w_sum >= {1'b0, capture_len_i});

`ifdef AXI_TRACE_CTRL_TIMEOUT_EN
    localparam int unsigned IdleWidth = $clog2(TimeoutCycles + 1);

    logic [IdleWidth-1:0] r_idle, w_idle_nxt;
    logic                 w_idle_expire;

    assign w_idle_expire = (w_qual == '0) && (r_idle == IdleWidth'(TimeoutCycles - 1));

    // Idle counter runs only in CAPTURE, so entering CAPTURE starts it at 0
    always_comb begin
        w_idle_nxt = '0;
        if ((r_state == ST_CAPTURE) && (w_qual == '0) && !w_idle_expire)
            w_idle_nxt = r_idle + IdleWidth'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_idle <= '0;
        else         r_idle <= w_idle_nxt;
    end
`endif

    // Next-state and counter/flag update
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_trig_nxt  = r_triggered;
        w_to_nxt    = r_timeout;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_arm) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_nxt   = '0;
                    w_trig_nxt  = 1'b0;
                    w_to_nxt    = 1'b0;
                end
            end
            ST_ARMED: begin
                if (w_trig) begin
                    w_trig_nxt  = 1'b1;
                    w_cnt_nxt   = w_cnt_sat;
                    w_state_nxt = w_len_done ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_cnt_nxt = w_cnt_sat;
                if (w_len_done) begin
                    w_state_nxt = ST_DONE;
                end
`ifdef AXI_TRACE_CTRL_TIMEOUT_EN
                else if (w_idle_expire) begin
                    w_state_nxt = ST_DONE;
                    w_to_nxt    = 1'b1;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (disarm_i) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_triggered <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_cnt_nxt;
            r_triggered <= w_trig_nxt;
            r_timeout   <= w_to_nxt;
        end
    end

    assign state_o     = r_state;
    assign beat_cnt_o  = r_beat_cnt;
    assign triggered_o = r_triggered;
    assign timeout_o   = r_timeout;

    // Payload fields and the timeout limit are not needed in every build
    assign w_unused = ^{axi_req_i, axi_resp_i, TimeoutCycles};

endmodule

// File: tb/tb_axi_trace_ctrl.sv
// Testbench for axi_trace_ctrl: table-driven vectors followed by directed
// multi-cycle sequences (saturation, arm/disarm collision, reset, timeout).

module tb_axi_trace_ctrl;
    import axi_trace_pkg::*;

    localparam logic [4:0] AW = 5'b00001;
    localparam logic [4:0] AR = 5'b00010;
    localparam logic [4:0] W  = 5'b00100;
    localparam logic [4:0] B  = 5'b01000;
    localparam logic [4:0] R  = 5'b10000;
    localparam logic [4:0] ALL = 5'b11111;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    axi_req_t    req;
    axi_resp_t   resp;
    logic        arm_i, disarm_i, trig_on_aw_i, trig_on_ar_i;
    logic [63:0] trig_base_i, trig_mask_i;
    logic [4:0]  chan_en_i;
    logic [15:0] capture_len_i;
    logic [4:0]  log_valid_o;
    logic [1:0]  state_o;
    logic [15:0] beat_cnt_o;
    logic        triggered_o, timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    axi_trace_ctrl #(
        .axi_req_t    (axi_req_t),
        .axi_resp_t   (axi_resp_t),
        .AddrWidth    (64),
        .CntWidth     (16),
        .TimeoutCycles(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .axi_req_i    (req),
        .axi_resp_i   (resp),
        .arm_i        (arm_i),
        .disarm_i     (disarm_i),
        .trig_on_aw_i (trig_on_aw_i),
        .trig_on_ar_i (trig_on_ar_i),
        .trig_base_i  (trig_base_i),
        .trig_mask_i  (trig_mask_i),
        .chan_en_i    (chan_en_i),
        .capture_len_i(capture_len_i),
        .log_valid_o  (log_valid_o),
        .state_o      (state_o),
        .beat_cnt_o   (beat_cnt_o),
        .triggered_o  (triggered_o),
        .timeout_o    (timeout_o)
    );

    typedef struct {
        logic        arm, dis, t_aw, t_ar;
        logic [4:0]  en;
        logic [15:0] len;
        logic [4:0]  vld, rdy;
        logic [63:0] aw_a, ar_a;
        logic [4:0]  e_log;
        logic [1:0]  e_st;
        logic [15:0] e_cnt;
        logic        e_trig;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic arm, dis, t_aw, t_ar, input logic [4:0] en,
                                input logic [15:0] len, input logic [4:0] vld, rdy,
                                input logic [63:0] aw_a, ar_a, input logic [4:0] e_log,
                                input logic [1:0] e_st, input logic [15:0] e_cnt,
                                input logic e_trig);
        vec_t v;
        v.arm = arm; v.dis = dis; v.t_aw = t_aw; v.t_ar = t_ar; v.en = en; v.len = len;
        v.vld = vld; v.rdy = rdy; v.aw_a = aw_a; v.ar_a = ar_a;
        v.e_log = e_log; v.e_st = e_st; v.e_cnt = e_cnt; v.e_trig = e_trig;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name, input logic [1:0] st, input logic [15:0] cnt,
                            input logic trig);
        check({name, " state"}, 64'(state_o), 64'(st));
        check({name, " cnt"}, 64'(beat_cnt_o), 64'(cnt));
        check({name, " trig"}, 64'(triggered_o), 64'(trig));
    endtask

    task automatic drive(input logic arm, dis, input logic [4:0] vld, rdy,
                         input logic [63:0] aw_a, ar_a);
        arm_i = arm;
        disarm_i = dis;
        req.aw_valid  = vld[0]; resp.aw_ready = rdy[0];
        req.ar_valid  = vld[1]; resp.ar_ready = rdy[1];
        req.w_valid   = vld[2]; resp.w_ready  = rdy[2];
        resp.b_valid  = vld[3]; req.b_ready   = rdy[3];
        resp.r_valid  = vld[4]; req.r_ready   = rdy[4];
        req.aw.addr   = aw_a;
        req.ar.addr   = ar_a;
    endtask

    task automatic clk_edge;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 5'b0, 5'b0, 64'h0, 64'h0);
    endtask

    initial begin
        // {arm,dis,t_aw,t_ar,en,len,vld,rdy,aw,ar | log,state,cnt,trig}
        vecs[0]  = mk(1,0,0,1, AR|R, 3, 0, 0, 0, 0,                            0, 1, 0, 0);
        vecs[1]  = mk(0,0,0,1, AR|R, 3, AR, AR, 0, 64'h8000_0010,              AR, 2, 1, 1);
        vecs[2]  = mk(0,0,0,1, AR|R, 3, R, R, 0, 0,                            R, 2, 2, 1);
        vecs[3]  = mk(0,0,0,1, AR|R, 3, R, 0, 0, 0,                            0, 2, 2, 1);
        vecs[4]  = mk(0,0,0,1, AR|R, 3, R, R, 0, 0,                            R, 3, 3, 1);
        vecs[5]  = mk(0,0,0,1, AR|R, 3, R, R, 0, 0,                            0, 3, 3, 1);
        vecs[6]  = mk(1,0,0,1, ALL, 3, 0, 0, 0, 0,                             0, 1, 0, 0);
        vecs[7]  = mk(0,0,1,1, ALL, 3, AW|AR, 0, 64'h8000_0000, 64'h8000_0000, 0, 1, 0, 0);
        vecs[8]  = mk(0,0,0,1, ALL, 3, AW, AW, 64'h8000_0000, 0,               0, 1, 0, 0);
        vecs[9]  = mk(0,0,0,1, ALL, 3, AR, AR, 0, 64'h4000_0000,               0, 1, 0, 0);
        vecs[10] = mk(0,0,0,1, ALL, 3, W|B|R, W|B|R, 0, 0,                     0, 1, 0, 0);
        vecs[11] = mk(0,0,1,1, ALL, 2, AW|W|B, AW|W|B, 64'h8000_0ABC, 0,       AW|W|B, 3, 3, 1);
        vecs[12] = mk(1,0,1,1, ALL, 2, 0, 0, 0, 0,                             0, 1, 0, 0);
        vecs[13] = mk(0,0,0,1, 5'b11101, 0, AR|R, AR|R, 0, 64'h8000_0000,      R, 2, 1, 1);
        vecs[14] = mk(0,0,0,1, 5'b11101, 0, ALL, ALL, 0, 0,                    5'b11101, 2, 5, 1);
        vecs[15] = mk(1,0,0,1, 5'b11101, 0, W, W, 0, 0,                        W, 2, 6, 1);
        vecs[16] = mk(0,1,0,1, 5'b11101, 0, 0, 0, 0, 0,                        0, 0, 6, 1);
        vecs[17] = mk(0,0,1,1, ALL, 0, ALL, ALL, 64'h8000_0000, 64'h8000_0000, 0, 0, 6, 1);
        vecs[18] = mk(1,1,1,1, ALL, 0, 0, 0, 0, 0,                             0, 0, 6, 1);

        req = '0;
        resp = '0;
        arm_i = 0; disarm_i = 0; trig_on_aw_i = 0; trig_on_ar_i = 0;
        trig_base_i = 64'h8000_0000;
        trig_mask_i = 64'hFFFF_F000;
        chan_en_i = 0; capture_len_i = 0;
        rst_ni = 0;
        clk_edge;
        clk_edge;
        chk_regs("reset", 0, 0, 0);
        check("reset timeout", 64'(timeout_o), 64'd0);
        check("reset log", 64'(log_valid_o), 64'd0);
        rst_ni = 1;

        for (int i = 0; i < 19; i++) begin
            trig_on_aw_i = vecs[i].t_aw;
            trig_on_ar_i = vecs[i].t_ar;
            chan_en_i = vecs[i].en;
            capture_len_i = vecs[i].len;
            drive(vecs[i].arm, vecs[i].dis, vecs[i].vld, vecs[i].rdy, vecs[i].aw_a, vecs[i].ar_a);
            #3;
            check($sformatf("vec%0d log", i), 64'(log_valid_o), 64'(vecs[i].e_log));
            clk_edge;
            chk_regs($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_cnt, vecs[i].e_trig);
        end

        // Arm and disarm together from DONE: disarm wins, count and flag hold
        trig_on_aw_i = 0; trig_on_ar_i = 1; chan_en_i = AR; capture_len_i = 1;
        drive(1, 0, 0, 0, 0, 0);
        clk_edge;
        chk_regs("seqA arm", 1, 0, 0);
        drive(0, 0, AR, AR, 0, 64'h8000_0FFF);
        #3;
        check("seqA trig log", 64'(log_valid_o), 64'(AR));
        clk_edge;
        chk_regs("seqA done", 3, 1, 1);
        drive(1, 1, 0, 0, 0, 0);
        clk_edge;
        chk_regs("seqA armdis", 0, 1, 1);

        // Unlimited window: 70000 R beats saturate the counter
        chan_en_i = R; capture_len_i = 0;
        drive(1, 0, 0, 0, 0, 0);
        clk_edge;
        drive(0, 0, AR|R, AR|R, 0, 64'h8000_0000);
        clk_edge;
        chk_regs("seqB trig", 2, 1, 1);
        drive(0, 0, R, R, 0, 0);
        for (int i = 0; i < 65533; i++) clk_edge;
        chk_regs("seqB pre-sat", 2, 16'hFFFE, 1);
        clk_edge;
        chk_regs("seqB sat", 2, 16'hFFFF, 1);
        for (int i = 0; i < 4465; i++) clk_edge;
        chk_regs("seqB 70000", 2, 16'hFFFF, 1);
        check("seqB log", 64'(log_valid_o), 64'(R));
        drive(0, 1, R, R, 0, 0);
        clk_edge;
        chk_regs("seqB disarm", 0, 16'hFFFF, 1);

        // Synchronous reset in the middle of a window
        chan_en_i = ALL; capture_len_i = 0;
        drive(1, 0, 0, 0, 0, 0);
        clk_edge;
        drive(0, 0, AR|R, AR|R, 0, 64'h8000_0000);
        clk_edge;
        chk_regs("seqC capture", 2, 2, 1);
        drive(0, 0, R, R, 0, 0);
        rst_ni = 0;
        clk_edge;
        chk_regs("seqC reset", 0, 0, 0);
        check("seqC timeout", 64'(timeout_o), 64'd0);
        check("seqC log", 64'(log_valid_o), 64'd0);
        rst_ni = 1;
        idle;
        clk_edge;

        // Idle window behaviour
        drive(1, 0, 0, 0, 0, 0);
        clk_edge;
        drive(0, 0, AR, AR, 0, 64'h8000_0000);
        clk_edge;
        idle;
`ifdef AXI_TRACE_CTRL_TIMEOUT_EN
        for (int i = 0; i < 7; i++) clk_edge;
        chk_regs("seqD 7 idle", 2, 1, 1);
        check("seqD 7 idle timeout", 64'(timeout_o), 64'd0);
        clk_edge;
        chk_regs("seqD 8 idle", 3, 1, 1);
        check("seqD timeout set", 64'(timeout_o), 64'd1);
        drive(1, 0, 0, 0, 0, 0);
        clk_edge;
        check("seqD rearm timeout", 64'(timeout_o), 64'd0);
        drive(0, 0, AR, AR, 0, 64'h8000_0000);
        clk_edge;
        idle;
        for (int i = 0; i < 5; i++) clk_edge;
        drive(0, 0, R, R, 0, 0);
        clk_edge;
        idle;
        for (int i = 0; i < 7; i++) clk_edge;
        chk_regs("seqD restart", 2, 2, 1);
        clk_edge;
        chk_regs("seqD restart expire", 3, 2, 1);
        check("seqD restart timeout", 64'(timeout_o), 64'd1);
`else
        for (int i = 0; i < 20; i++) clk_edge;
        chk_regs("seqD no timeout", 2, 1, 1);
        check("seqD timeout low", 64'(timeout_o), 64'd0);
        drive(0, 1, 0, 0, 0, 0);
        clk_edge;
        chk_regs("seqD disarm", 0, 1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
